// File: rtl/flags_pkg.sv
// Shared definitions for the flag-register write scheduler.
// Flag bit positions inside {Z,N,C,V}, condition codes, FSM states, and the
// branch-condition evaluator used by flags_ctrl.
package flags_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } state_e;

    // Evaluate a branch condition against a {Z,N,C,V} flag vector.
    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic z, n, c, v;
        logic res;
        z = f[FLAG_Z];
        n = f[FLAG_N];
        c = f[FLAG_C];
        v = f[FLAG_V];
        res = 1'b0;
        case (cond_e'(code))
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flags_shadow_stack.sv
// LIFO of flag snapshots for interrupt save/restore.
// dout always presents the top entry combinationally; push when full and
// pop when empty are ignored here (the caller flags them as errors).
module flags_shadow_stack #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [3:0]       din,
    output logic [3:0]       dout,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic [3:0]       mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign dout    = mem_q[top_idx];
    assign cnt     = cnt_q;

    // Occupancy update; a simultaneous push and pop replaces the top entry.
    always_comb begin
        cnt_d  = cnt_q;
        wr_idx = IDX_W'(cnt_q);
        if (do_push && do_pop) begin
            wr_idx = top_idx;
        end else if (push && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Occupancy counter, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/flags_ctrl.sv
// Flag register write-port scheduler and branch condition evaluator.
// Arbitrates restore > save > load > ALU, drives a registered write port,
// keeps an interrupt shadow stack and evaluates cond_code over the flags.
// Build option FLAGS_BYPASS_EN: conditions see flag_wdata in the cycle it is
// written; otherwise they see flag_rdata only.
module flags_ctrl
    import flags_pkg::*;
#(
    parameter  int STK_DEPTH = 4,
    localparam int CNT_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       flag_rdata,
    output logic [3:0]       flag_wdata,
    output logic             flag_we,
    input  logic             alu_valid,
    input  logic             alu_setf,
    input  logic [3:0]       alu_flags,
    output logic             alu_ready,
    input  logic             ld_req,
    input  logic [3:0]       ld_flags,
    output logic             ld_gnt,
    input  logic             save_req,
    output logic             save_gnt,
    input  logic             restore_req,
    output logic             restore_gnt,
    output logic             busy,
    output logic [CNT_W-1:0] stk_cnt,
    output logic             stk_err,
    input  logic [3:0]       cond_code,
    output logic             cond_true
);

    state_e     state_q, state_d;
    logic [3:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic [3:0] hold_q, hold_d;
    logic       err_q, err_d;

    logic       idle;
    logic       stk_push;
    logic       stk_pop;
    logic [3:0] stk_din;
    logic [3:0] stk_dout;
    logic       stk_full;
    logic       stk_empty;
    logic [3:0] cond_flags;

    // Fixed-priority grants, only while idle.
    always_comb begin
        idle        = (state_q == ST_IDLE);
        restore_gnt = idle & restore_req;
        save_gnt    = idle & save_req & ~restore_req;
        ld_gnt      = idle & ld_req & ~restore_req & ~save_req;
        alu_ready   = idle & alu_valid & ~restore_req & ~save_req & ~ld_req;
    end

    // A save captures the value being committed this cycle if there is one.
    always_comb begin
        stk_din  = we_q ? wdata_q : flag_rdata;
        stk_push = save_gnt;
        stk_pop  = restore_gnt;
    end

    flags_shadow_stack #(
        .DEPTH (STK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .cnt   (stk_cnt),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-state for the FSM, write port, restore hold register and error flag.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        err_d   = err_q | (save_gnt & stk_full) | (restore_gnt & stk_empty);
        case (state_q)
            ST_RESTORE: begin
                state_d = ST_IDLE;
                we_d    = 1'b1;
                wdata_d = hold_q;
            end
            default: begin
                if (restore_gnt && !stk_empty) begin
                    state_d = ST_RESTORE;
                    hold_d  = stk_dout;
                end
                if (ld_gnt) begin
                    we_d    = 1'b1;
                    wdata_d = ld_flags;
                end
                if (alu_ready && alu_setf) begin
                    we_d    = 1'b1;
                    wdata_d = alu_flags;
                end
            end
        endcase
    end

    // Controller registers; reset aborts any restore without writing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign flag_wdata = wdata_q;
    assign flag_we    = we_q;
    assign busy       = (state_q == ST_RESTORE);
    assign stk_err    = err_q;

    // Flag source for branch evaluation.
    always_comb begin
`ifdef FLAGS_BYPASS_EN
        cond_flags = we_q ? wdata_q : flag_rdata;
`else
        cond_flags = flag_rdata;
`endif
        cond_true = eval_cond(cond_code, cond_flags);
    end

endmodule

// File: tb/tb_flags_ctrl.sv
// Self-checking bench for flags_ctrl: expected flag writes are queued when a
// request is granted and popped by a monitor whenever flag_we is seen.
module tb_flags_ctrl;

    localparam int STK_DEPTH = 4;
    localparam int CNT_W     = $clog2(STK_DEPTH + 1);

    logic             clk;
    logic             rst;
    logic [3:0]       flag_rdata;
    logic [3:0]       flag_wdata;
    logic             flag_we;
    logic             alu_valid;
    logic             alu_setf;
    logic [3:0]       alu_flags;
    logic             alu_ready;
    logic             ld_req;
    logic [3:0]       ld_flags;
    logic             ld_gnt;
    logic             save_req;
    logic             save_gnt;
    logic             restore_req;
    logic             restore_gnt;
    logic             busy;
    logic [CNT_W-1:0] stk_cnt;
    logic             stk_err;
    logic [3:0]       cond_code;
    logic             cond_true;

    int         vectors;
    int         miscompares;
    logic [3:0] exp_q [$];

    flags_ctrl #(.STK_DEPTH(STK_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flag_rdata  (flag_rdata),
        .flag_wdata  (flag_wdata),
        .flag_we     (flag_we),
        .alu_valid   (alu_valid),
        .alu_setf    (alu_setf),
        .alu_flags   (alu_flags),
        .alu_ready   (alu_ready),
        .ld_req      (ld_req),
        .ld_flags    (ld_flags),
        .ld_gnt      (ld_gnt),
        .save_req    (save_req),
        .save_gnt    (save_gnt),
        .restore_req (restore_req),
        .restore_gnt (restore_gnt),
        .busy        (busy),
        .stk_cnt     (stk_cnt),
        .stk_err     (stk_err),
        .cond_code   (cond_code),
        .cond_true   (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && flag_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: flag_we=1 wdata=%b, no write expected", flag_wdata);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (flag_wdata !== e) begin
                    miscompares++;
                    $display("FAIL wr_data: got %b expected %b", flag_wdata, e);
                end
            end
        end
    end

    task automatic clear_inputs();
        alu_valid   = 1'b0;
        alu_setf    = 1'b0;
        alu_flags   = 4'b0;
        ld_req      = 1'b0;
        ld_flags    = 4'b0;
        save_req    = 1'b0;
        restore_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        // Park one entry, start a restore and assert reset while it is in flight.
        @(negedge clk);
        flag_rdata = 4'b1111;
        save_req   = 1'b1;
        @(negedge clk);
        save_req    = 1'b0;
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_busy_pre: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({flag_we, busy, stk_err, stk_cnt, flag_wdata} !== {3'b000, CNT_W'(0), 4'b0000}) begin
            miscompares++;
            $display("FAIL rst_state: we=%b busy=%b err=%b cnt=%0d wdata=%b expected all 0",
                     flag_we, busy, stk_err, stk_cnt, flag_wdata);
        end
        @(negedge clk);
        vectors++;
        if (flag_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort_we: got %b expected 0", flag_we);
        end
        cond_code = 4'd14;
        #1;
        vectors++;
        if (cond_true !== 1'b1) begin
            miscompares++;
            $display("FAIL cond_al: got %b expected 1", cond_true);
        end
        cond_code = 4'd15;
        #1;
        vectors++;
        if (cond_true !== 1'b0) begin
            miscompares++;
            $display("FAIL cond_nv: got %b expected 0", cond_true);
        end
        rst = 1'b1;
        flag_rdata = 4'b0000;
    endtask

    task automatic test_alu();
        @(negedge clk);
        alu_valid = 1'b1;
        alu_setf  = 1'b1;
        alu_flags = 4'b1000;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_ready_set: got %b expected 1", alu_ready);
        end
        exp_q.push_back(4'b1000);
        @(negedge clk);
        clear_inputs();
        vectors++;
        if (flag_we !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_we: got %b expected 1", flag_we);
        end
        @(negedge clk);
        vectors++;
        if (flag_we !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_we_once: got %b expected 0", flag_we);
        end
        // No-setf instruction: accepted but never written.
        alu_valid = 1'b1;
        alu_setf  = 1'b0;
        alu_flags = 4'b0111;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_ready_noset: got %b expected 1", alu_ready);
        end
        @(negedge clk);
        clear_inputs();
        vectors++;
        if (flag_we !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_noset_we: got %b expected 0", flag_we);
        end
    endtask

    task automatic test_save_restore();
        @(negedge clk);
        flag_rdata = 4'b0101;
        save_req   = 1'b1;
        #1;
        vectors++;
        if (save_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL sr_save_gnt: got %b expected 1", save_gnt);
        end
        @(negedge clk);
        save_req = 1'b0;
        vectors++;
        if (stk_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL sr_cnt1: got %0d expected 1", stk_cnt);
        end
        ld_req   = 1'b1;
        ld_flags = 4'b0010;
        #1;
        vectors++;
        if (ld_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL sr_ld_gnt: got %b expected 1", ld_gnt);
        end
        exp_q.push_back(4'b0010);
        @(negedge clk);
        clear_inputs();
        restore_req = 1'b1;
        #1;
        vectors++;
        if (restore_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL sr_restore_gnt: got %b expected 1", restore_gnt);
        end
        exp_q.push_back(4'b0101);
        @(negedge clk);
        restore_req = 1'b0;
        vectors++;
        if ({busy, flag_we, stk_cnt} !== {2'b10, CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL sr_busy: busy=%b we=%b cnt=%0d expected busy=1 we=0 cnt=0",
                     busy, flag_we, stk_cnt);
        end
        @(negedge clk);
        vectors++;
        if ({busy, flag_we} !== 2'b01) begin
            miscompares++;
            $display("FAIL sr_done: busy=%b we=%b expected busy=0 we=1", busy, flag_we);
        end
        flag_rdata = 4'b0000;
    endtask

    task automatic test_bounds();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            save_req = 1'b1;
            #1;
            vectors++;
            if (save_gnt !== 1'b1) begin
                miscompares++;
                $display("FAIL bnd_save_gnt%0d: got %b expected 1", i, save_gnt);
            end
            if (i == 4) begin
                vectors++;
                if ({stk_cnt, stk_err} !== {CNT_W'(4), 1'b0}) begin
                    miscompares++;
                    $display("FAIL bnd_full_noerr: cnt=%0d err=%b expected 4/0", stk_cnt, stk_err);
                end
            end
        end
        @(negedge clk);
        save_req = 1'b0;
        vectors++;
        if ({stk_cnt, stk_err} !== {CNT_W'(4), 1'b1}) begin
            miscompares++;
            $display("FAIL bnd_overflow: cnt=%0d err=%b expected 4/1", stk_cnt, stk_err);
        end
        do_reset();
        @(negedge clk);
        restore_req = 1'b1;
        #1;
        vectors++;
        if (restore_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL bnd_empty_gnt: got %b expected 1", restore_gnt);
        end
        @(negedge clk);
        restore_req = 1'b0;
        vectors++;
        if ({flag_we, busy, stk_err, stk_cnt} !== {3'b001, CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL bnd_underflow: we=%b busy=%b err=%b cnt=%0d expected 0/0/1/0",
                     flag_we, busy, stk_err, stk_cnt);
        end
        do_reset();
    endtask

    task automatic test_priority();
        @(negedge clk);
        flag_rdata = 4'b1100;
        save_req   = 1'b1;
        @(negedge clk);
        save_req    = 1'b0;
        flag_rdata  = 4'b0000;
        restore_req = 1'b1;
        ld_req      = 1'b1;
        ld_flags    = 4'b1011;
        alu_valid   = 1'b1;
        alu_setf    = 1'b1;
        alu_flags   = 4'b0001;
        #1;
        vectors++;
        if ({restore_gnt, save_gnt, ld_gnt, alu_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL pri_grant: rgs la=%b%b%b%b expected 1000",
                     restore_gnt, save_gnt, ld_gnt, alu_ready);
        end
        exp_q.push_back(4'b1100);
        @(negedge clk);
        restore_req = 1'b0;
        #1;
        vectors++;
        if ({busy, restore_gnt, save_gnt, ld_gnt, alu_ready} !== 5'b10000) begin
            miscompares++;
            $display("FAIL pri_busy_nogrant: busy/grants=%b%b%b%b%b expected 10000",
                     busy, restore_gnt, save_gnt, ld_gnt, alu_ready);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        vectors++;
        if ({busy, ld_gnt} !== 2'b01) begin
            miscompares++;
            $display("FAIL pri_ld_after: busy=%b ld_gnt=%b expected 0/1", busy, ld_gnt);
        end
        exp_q.push_back(4'b1011);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // A save in the cycle a write lands must capture the new value.
        @(negedge clk);
        flag_rdata = 4'b0000;
        alu_valid  = 1'b1;
        alu_setf   = 1'b1;
        alu_flags  = 4'b0011;
        exp_q.push_back(4'b0011);
        @(negedge clk);
        clear_inputs();
        save_req = 1'b1;
        @(negedge clk);
        save_req    = 1'b0;
        restore_req = 1'b1;
        exp_q.push_back(4'b0011);
        @(negedge clk);
        restore_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (stk_cnt !== CNT_W'(0)) begin
            miscompares++;
            $display("FAIL b2b_cnt: got %0d expected 0", stk_cnt);
        end
    endtask

    task automatic test_cond();
        logic [3:0] codes [3];
        logic       exp_v [3];
        logic       exp_eq;
        codes[0] = 4'd10; exp_v[0] = 1'b0;
        codes[1] = 4'd11; exp_v[1] = 1'b1;
        codes[2] = 4'd8;  exp_v[2] = 1'b1;
        @(negedge clk);
        flag_rdata = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            cond_code = codes[i];
            #1;
            vectors++;
            if (cond_true !== exp_v[i]) begin
                miscompares++;
                $display("FAIL cond_code%0d: got %b expected %b", codes[i], cond_true, exp_v[i]);
            end
        end
        alu_valid = 1'b1;
        alu_setf  = 1'b1;
        alu_flags = 4'b1000;
        exp_q.push_back(4'b1000);
        @(negedge clk);
        clear_inputs();
        cond_code = 4'd0;
`ifdef FLAGS_BYPASS_EN
        exp_eq = 1'b1;
`else
        exp_eq = 1'b0;
`endif
        #1;
        vectors++;
        if ({flag_we, cond_true} !== {1'b1, exp_eq}) begin
            miscompares++;
            $display("FAIL cond_bypass_eq: we=%b eq=%b expected we=1 eq=%b", flag_we, cond_true, exp_eq);
        end
        @(negedge clk);
        flag_rdata = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        flag_rdata  = 4'b0000;
        cond_code   = 4'd0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_alu();
        test_save_restore();
        test_bounds();
        test_priority();
        test_back_to_back();
        test_cond();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wr_missing: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
